// File: rtl/mem_pkg.sv
// Shared CPU/memory bus definitions: FSM states, access direction and error encodings.
package mem_pkg;

   localparam int unsigned MEM_DW = 32;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   localparam logic [1:0] MEM_ERR_NONE    = 2'd0;
   localparam logic [1:0] MEM_ERR_RANGE   = 2'd1;
   localparam logic [1:0] MEM_ERR_PROTECT = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_e;

endpackage

// File: rtl/memresp_ram.sv
// Single-port synchronous RAM, word addressed, registered read, no reset on contents.
module memresp_ram
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] index,
   input  logic [MEM_DW-1:0]     wdata,
   output logic [MEM_DW-1:0]     rdata
);

   logic [MEM_DW-1:0] mem [2**DEPTH_LOG2];

   // Read-first: a same-edge write is not visible until the following read.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[index] <= wdata;
      end
      rdata <= mem[index];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder with fixed wait-state latency over a single-port RAM.
// Optional write protection of low addresses is enabled by MEMRESP_WRITE_PROTECT_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2    = 10,
   parameter int unsigned WAIT_STATES   = 1,
   parameter int unsigned PROTECT_LIMIT = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic [31:0]       address,
   input  logic [MEM_DW-1:0] wdata,
   output logic [MEM_DW-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy
);

`ifdef MEMRESP_WRITE_PROTECT_EN
   localparam bit PROTECT_EN = 1'b1;
`else
   localparam bit PROTECT_EN = 1'b0;
`endif

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   function automatic logic [1:0] access_err(input logic [31:0] a, input logic w);
      logic [1:0] code;
      code = MEM_ERR_NONE;
      if (a[31:DEPTH_LOG2] != '0) begin
         code = MEM_ERR_RANGE;
      end else if (PROTECT_EN && (w == MEM_WR) && (a < 32'(PROTECT_LIMIT))) begin
         code = MEM_ERR_PROTECT;
      end
      return code;
   endfunction

   mem_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q;
   logic              rw_q;
   logic [MEM_DW-1:0] wdata_q;
   logic [MEM_DW-1:0] rdata_q;

   logic              enter_resp;
   logic [31:0]       src_addr;
   logic              src_rw;
   logic [MEM_DW-1:0] src_wdata;
   logic              ram_we;
   logic [MEM_DW-1:0] ram_rdata;
   logic [1:0]        resp_err;

   // In IDLE the only path into RESP is a zero-wait accept, so use the live bus fields.
   always_comb begin
      src_addr  = addr_q;
      src_rw    = rw_q;
      src_wdata = wdata_q;
      if (state_q == IDLE) begin
         src_addr  = address;
         src_rw    = rw;
         src_wdata = wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d = WS;
               if (WAIT_STATES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
            cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ram_we = enter_resp && !reset && (src_rw == MEM_WR) &&
                   (access_err(src_addr, src_rw) == MEM_ERR_NONE);

   memresp_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clock(clock),
      .we   (ram_we),
      .index(src_addr[DEPTH_LOG2-1:0]),
      .wdata(src_wdata),
      .rdata(ram_rdata)
   );

   assign resp_err = access_err(addr_q, rw_q);
   assign busy     = (state_q != IDLE);
   assign ack      = (state_q == RESP);
   assign err      = ack && (resp_err != MEM_ERR_NONE);

   always_comb begin
      rdata = rdata_q;
      if ((state_q == RESP) && (rw_q == MEM_RD)) begin
         rdata = (resp_err != MEM_ERR_NONE) ? '0 : ram_rdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         rw_q    <= MEM_RD;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == IDLE) && req) begin
            addr_q  <= address;
            rw_q    <= rw;
            wdata_q <= wdata;
         end
         // Capture the completed read so rdata holds once ack drops.
         if ((state_q == RESP) && (rw_q == MEM_RD)) begin
            rdata_q <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req, rw;
   logic [31:0] address, wdata, rdata;
   logic        ack, err, busy;

   logic        req0, rw0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ack0, err0, busy0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mem_responder #(
      .DEPTH_LOG2 (10),
      .WAIT_STATES(2)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .rw     (rw),
      .address(address),
      .wdata  (wdata),
      .rdata  (rdata),
      .ack    (ack),
      .err    (err),
      .busy   (busy)
   );

   mem_responder #(
      .DEPTH_LOG2 (10),
      .WAIT_STATES(0)
   ) dut0 (
      .clock  (clock),
      .reset  (reset),
      .req    (req0),
      .rw     (rw0),
      .address(addr0),
      .wdata  (wdata0),
      .rdata  (rdata0),
      .ack    (ack0),
      .err    (err0),
      .busy   (busy0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat,
                      output int nbusy);
      rw = w; address = a; wdata = d; req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req = 1'b0; lat = 0; nbusy = 0; rd = '0; e = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (busy) nbusy++;
         if (ack) begin
            lat = n; rd = rdata; e = err;
            break;
         end
         @(negedge clock);
      end
      if (lat == 0) check("txn_timeout", 32'd0, 32'd1);
      @(negedge clock);
      check("ack_one_cycle", {31'd0, ack}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        e;
   int          lat, nb, acks;
   int          stamp [4];
   logic [31:0] cap;

   initial begin
      reset = 1'b1; req = 1'b0; rw = 1'b0; address = '0; wdata = '0;
      req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
      repeat (2) @(negedge clock);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Write then read with two wait states
      txn(1'b1, 32'd5, 32'hDEAD_BEEF, rd, e, lat, nb);
      check("wr5_lat", 32'(lat), 32'd3);
      check("wr5_busy_cycles", 32'(nb), 32'd3);
      check("wr5_err", {31'd0, e}, 32'd0);
      txn(1'b0, 32'd5, 32'h0, rd, e, lat, nb);
      check("rd5_lat", 32'(lat), 32'd3);
      check("rd5_data", rd, 32'hDEAD_BEEF);
      check("rd5_err", {31'd0, e}, 32'd0);
      check("rdata_hold", rdata, 32'hDEAD_BEEF);
      check("idle_busy", {31'd0, busy}, 32'd0);

      txn(1'b1, 32'd0, 32'hA5A5_0000, rd, e, lat, nb);
      txn(1'b1, 32'd1, 32'h0000_1111, rd, e, lat, nb);
      txn(1'b1, 32'd7, 32'h7777_7777, rd, e, lat, nb);

      // Out-of-range read
      txn(1'b0, 32'h0000_0400, 32'h0, rd, e, lat, nb);
      check("oor_err", {31'd0, e}, 32'd1);
      check("oor_rdata", rd, 32'd0);
      check("oor_lat", 32'(lat), 32'd3);
      txn(1'b0, 32'd0, 32'h0, rd, e, lat, nb);
      check("rd0_after_oor", rd, 32'hA5A5_0000);
      txn(1'b1, 32'h0000_0401, 32'hFFFF_FFFF, rd, e, lat, nb);
      check("oor_wr_err", {31'd0, e}, 32'd1);
      txn(1'b0, 32'd1, 32'h0, rd, e, lat, nb);
      check("rd1_after_oor_wr", rd, 32'h0000_1111);

      // Reset during WAIT discards an uncommitted write
      rw = 1'b1; address = 32'd7; wdata = 32'h0000_0BAD; req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req = 1'b0; reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ack", {31'd0, ack}, 32'd0);
      // Reset and req at the same edge: reset wins
      req = 1'b1; rw = 1'b0; address = 32'd5;
      @(posedge clock);
      @(negedge clock);
      check("rst_req_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0; req = 1'b0;
      @(negedge clock);
      txn(1'b0, 32'd7, 32'h0, rd, e, lat, nb);
      check("rd7_after_abort", rd, 32'h7777_7777);

      // Bus changes and a req pulse mid-transaction are ignored
      rw = 1'b0; address = 32'd5; req = 1'b1;
      @(posedge clock);
      acks = 0; cap = '0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clock);
         if (ack) begin
            acks++;
            cap = rdata;
         end
         if (n == 1) begin
            req = 1'b1; rw = 1'b1; address = 32'd1; wdata = 32'hFFFF_0000;
         end else begin
            req = 1'b0;
         end
      end
      check("busy_ack_count", 32'(acks), 32'd1);
      check("busy_rdata", cap, 32'hDEAD_BEEF);
      txn(1'b0, 32'd1, 32'h0, rd, e, lat, nb);
      check("rd1_untouched", rd, 32'h0000_1111);

`ifdef MEMRESP_WRITE_PROTECT_EN
      txn(1'b1, 32'd3, 32'h1234_5678, rd, e, lat, nb);
      check("prot_wr_err", {31'd0, e}, 32'd1);
      txn(1'b0, 32'd3, 32'h0, rd, e, lat, nb);
      check("prot_unchanged", {31'd0, rd == 32'h1234_5678}, 32'd0);
      check("prot_rd_err", {31'd0, e}, 32'd0);
`else
      txn(1'b1, 32'd3, 32'h1234_5678, rd, e, lat, nb);
      check("wr3_err", {31'd0, e}, 32'd0);
      txn(1'b0, 32'd3, 32'h0, rd, e, lat, nb);
      check("rd3_data", rd, 32'h1234_5678);
`endif
      txn(1'b1, 32'd100, 32'h0BAD_CAFE, rd, e, lat, nb);
      check("wr100_err", {31'd0, e}, 32'd0);
      txn(1'b0, 32'd100, 32'h0, rd, e, lat, nb);
      check("rd100_data", rd, 32'h0BAD_CAFE);

      // Zero wait states, req held high: one completion every two cycles
      req0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rw0    = (i < 2);
         addr0  = 32'(i % 2);
         wdata0 = 32'hC0DE_0000 + 32'(i);
         @(posedge clock);
         @(negedge clock);
         check("ws0_ack", {31'd0, ack0}, 32'd1);
         check("ws0_err", {31'd0, err0}, 32'd0);
         stamp[i] = cyc;
         if (i >= 2) check("ws0_rdata", rdata0, 32'hC0DE_0000 + 32'(i - 2));
         @(posedge clock);
         @(negedge clock);
         check("ws0_ack_gap", {31'd0, ack0}, 32'd0);
      end
      req0 = 1'b0;
      check("ws0_ack_spacing", 32'(stamp[3] - stamp[2]), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
